// File: rtl/fifo_stream_reader.sv
// Streams words from a registered-read FIFO into a valid/ready output through a
// 2-entry skid buffer, framing every Pkt_len words as a packet.
module fifo_stream_reader #(
  parameter int unsigned Width_data = 8,
  parameter int unsigned Pkt_len    = 4
) (
  input  logic                  sys_clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [Width_data-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [Width_data-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           pkt_cnt,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [7:0] LastIdx = 8'(Pkt_len - 1);

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q, infl_d;
  logic [Width_data-1:0] head_q, head_d;
  logic [Width_data-1:0] tail_q, tail_d;
  logic [7:0]            word_cnt_q, word_cnt_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;

  logic       pop;
  logic       last_hit;
  logic       rd_en;
  logic [2:0] occ_after;

  always_comb begin
    last_hit  = (word_cnt_q == LastIdx);
    pop       = (occ_q != 2'd0) & m_ready;
    // Occupancy once the pending capture and this cycle's pop have settled.
    occ_after = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    rd_en     = (state_q == RUN) & enable & !fifo_empty & (occ_after < 3'd2);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN:   if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) state_d = RUN;
        else if ((occ_q == 2'd0) && !infl_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    infl_d = rd_en;
    unique case ({infl_q, pop})
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) head_d = fifo_rd_data;
        else               tail_d = fifo_rd_data;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        // Capture and pop together: the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = fifo_rd_data;
        end else begin
          head_d = tail_q;
          tail_d = fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (pop) begin
      if (last_hit) begin
        word_cnt_d = '0;
        pkt_cnt_d  = pkt_cnt_q + 16'd1;
      end else begin
        word_cnt_d = word_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (srst) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      infl_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      infl_q     <= infl_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // Outputs are forced idle for the whole reset pulse, including its first cycle.
  always_comb begin
    fifo_rd_en = rd_en & !srst;
    m_valid    = (occ_q != 2'd0) & !srst;
    m_data     = srst ? '0 : head_q;
    m_last     = m_valid & last_hit;
    pkt_cnt    = srst ? '0 : pkt_cnt_q;
    busy       = (state_q != IDLE) & !srst;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-backed FIFO model feeds the DUT,
// expected words are queued at load time and popped by a monitor on each transfer.
module tb_fifo_stream_reader;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        srst = 1'b1, enable = 1'b0, m_ready = 1'b0;
  logic        fifo_empty = 1'b1, fifo_rd_en, m_valid, m_last, busy;
  logic [7:0]  fifo_rd_data = '0, m_data;
  logic [15:0] pkt_cnt;

  logic        enable1 = 1'b0, m_ready1 = 1'b0;
  logic        fifo_empty1 = 1'b1, fifo_rd_en1, m_valid1, m_last1, busy1;
  logic [7:0]  fifo_rd_data1 = '0, m_data1;
  logic [15:0] pkt_cnt1;

  fifo_stream_reader #(.Width_data(8), .Pkt_len(4)) dut (
    .sys_clk(sys_clk), .srst(srst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  fifo_stream_reader #(.Width_data(8), .Pkt_len(1)) dut1 (
    .sys_clk(sys_clk), .srst(srst), .enable(enable1), .fifo_empty(fifo_empty1),
    .fifo_rd_en(fifo_rd_en1), .fifo_rd_data(fifo_rd_data1), .m_valid(m_valid1),
    .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1), .pkt_cnt(pkt_cnt1), .busy(busy1)
  );

  typedef struct packed {logic [7:0] data; logic last;} exp_t;

  int   checks = 0, errors = 0;
  int   rd_count = 0, pop_count = 0, run_len = 0, max_run = 0;
  logic [7:0] fifo_q[$], fifo1_q[$];
  exp_t exp_q[$], exp1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // FIFO models: read data one cycle after the strobe, empty flag registered.
  always @(posedge sys_clk) begin
    if (fifo_rd_en) begin
      check("rd_while_empty", 32'(fifo_empty), 32'd0);
      rd_count++;
      if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge sys_clk) begin
    if (fifo_rd_en1) begin
      check("rd_while_empty1", 32'(fifo_empty1), 32'd0);
      if (fifo1_q.size() > 0) fifo_rd_data1 <= fifo1_q.pop_front();
    end
    fifo_empty1 <= (fifo1_q.size() == 0);
  end

  logic       prev_stall = 1'b0, prev_pop = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;
  exp_t       e, e1;

  always @(negedge sys_clk) begin
    if (srst) begin
      prev_stall = 1'b0;
      prev_pop   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_data));
        check("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", m_data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e.data));
          check("m_last", 32'(m_last), 32'(e.last));
        end
        pop_count++;
        run_len = prev_pop ? run_len + 1 : 1;
        if (run_len > max_run) max_run = run_len;
      end
      prev_pop   = m_valid && m_ready;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  always @(negedge sys_clk) begin
    if (!srst && m_valid1) begin
      check("len1_last", 32'(m_last1), 32'd1);
      if (m_ready1) begin
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word1 actual=%0h required=none", m_data1);
        end else begin
          e1 = exp1_q.pop_front();
          check("len1_data", 32'(m_data1), 32'(e1.data));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] base, input int n, input logic [7:0] last_mask);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + 8'(i));
      exp_q.push_back({base + 8'(i), last_mask[i]});
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base_rd, base_pop, k;

    tick(3);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    srst = 1'b0;
    tick(2);

    // Full-rate streaming of two packets.
    m_ready = 1'b1;
    load(8'h10, 8, 8'b1000_1000);
    tick(2);
    max_run = 0;
    enable = 1'b1;
    wait_drain("stream", 40);
    tick(2);
    check("stream_run_len", 32'(max_run), 32'd8);
    check("stream_pkt_cnt", 32'(pkt_cnt), 32'd2);
    enable = 1'b0;
    tick(4);
    check("stream_idle_busy", 32'(busy), 32'd0);

    // Downstream ready alternating 1-0.
    load(8'h20, 8, 8'b1000_1000);
    tick(2);
    enable = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      m_ready = ~m_ready;
      tick(1);
      k++;
    end
    check("toggle_drained", 32'(exp_q.size()), 32'd0);
    m_ready = 1'b1;
    tick(2);
    check("toggle_pkt_cnt", 32'(pkt_cnt), 32'd4);
    enable = 1'b0;
    tick(4);

    // Backpressure: buffer fills to two words, no further reads.
    m_ready = 1'b0;
    load(8'h30, 4, 8'b0000_1000);
    tick(2);
    base_rd = rd_count;
    enable = 1'b1;
    tick(10);
    check("bp_reads", 32'(rd_count - base_rd), 32'd2);
    check("bp_fifo_left", 32'(fifo_q.size()), 32'd2);
    check("bp_m_valid", 32'(m_valid), 32'd1);
    check("bp_head", 32'(m_data), 32'h30);
    m_ready = 1'b1;
    wait_drain("bp", 40);
    tick(2);
    check("bp_pkt_cnt", 32'(pkt_cnt), 32'd5);
    enable = 1'b0;
    tick(4);

    // Enable drop with a full buffer, drain, then resume mid-packet.
    m_ready = 1'b0;
    load(8'h40, 8, 8'b1000_1000);
    tick(2);
    base_rd = rd_count;
    enable = 1'b1;
    tick(8);
    check("drain_reads", 32'(rd_count - base_rd), 32'd2);
    enable = 1'b0;
    tick(1);
    check("drain_busy", 32'(busy), 32'd1);
    base_pop = pop_count;
    m_ready = 1'b1;
    tick(6);
    check("drain_pops", 32'(pop_count - base_pop), 32'd2);
    check("drain_busy_fell", 32'(busy), 32'd0);
    check("drain_fifo_left", 32'(fifo_q.size()), 32'd6);
    enable = 1'b1;
    wait_drain("resume", 40);
    tick(2);
    check("resume_pkt_cnt", 32'(pkt_cnt), 32'd7);
    enable = 1'b0;
    tick(4);

    // Reset with a buffered word and another in flight.
    m_ready = 1'b0;
    load(8'h50, 4, 8'b0000_1000);
    tick(2);
    base_rd = rd_count;
    enable = 1'b1;
    k = 0;
    while (rd_count < base_rd + 2 && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    check("rst_mid_reads", 32'(rd_count - base_rd), 32'd2);
    srst = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    tick(1);
    check("rst_mid_m_valid", 32'(m_valid), 32'd0);
    check("rst_mid_m_data", 32'(m_data), 32'd0);
    check("rst_mid_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_mid_rd_en", 32'(fifo_rd_en), 32'd0);
    srst = 1'b0;
    tick(1);
    check("post_rst_m_valid", 32'(m_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    // 0x50 was buffered, 0x51 in flight: both are gone; 0x52 starts a new packet.
    exp_q.push_back({8'h52, 1'b0});
    exp_q.push_back({8'h53, 1'b0});
    exp_q.push_back({8'h54, 1'b0});
    exp_q.push_back({8'h55, 1'b1});
    fifo_q.push_back(8'h54);
    fifo_q.push_back(8'h55);
    m_ready = 1'b1;
    tick(2);
    enable = 1'b1;
    wait_drain("post_rst", 40);
    tick(2);
    check("post_rst_pkt_done", 32'(pkt_cnt), 32'd1);
    enable = 1'b0;
    tick(4);

    // Single-word packets.
    for (int i = 0; i < 3; i++) begin
      fifo1_q.push_back(8'h60 + 8'(i));
      exp1_q.push_back({8'h60 + 8'(i), 1'b1});
    end
    m_ready1 = 1'b1;
    tick(2);
    enable1 = 1'b1;
    k = 0;
    while (exp1_q.size() != 0 && k < 40) begin
      tick(1);
      k++;
    end
    check("len1_drained", 32'(exp1_q.size()), 32'd0);
    tick(2);
    check("len1_pkt_cnt", 32'(pkt_cnt1), 32'd3);
    enable1 = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
